mult_datapath: RTL and testbench

- Shift-add multiplier datapath. It is the downstream stage of the multiplier control FSM.
- It consumes the FSM's one-cycle control strobes: load, add, shift, decrement and ready.
- It returns two status bits to the FSM: zero (iteration counter empty) and pulso (current multiplier LSB).
- It holds the accumulator, multiplicand, multiplier/shift and counter registers. It publishes the final product when ready is strobed.

---
 rtl/mult_pkg.sv | 7 +
 rtl/mult_iter_counter.sv | 34 +++
 rtl/mult_datapath.sv | 127 ++++++++++++
 tb/tb_mult_datapath.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier datapath and its controller.
package mult_pkg;
    localparam int MULT_WIDTH = 8;

    typedef logic [MULT_WIDTH-1:0]   operand_t;
    typedef logic [2*MULT_WIDTH-1:0] product_t;
endpackage

// File: rtl/mult_iter_counter.sv
// Down-counter for iterative units: loads WIDTH, decrements and saturates at zero.
module mult_iter_counter
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);
    logic [CNT_W-1:0] p_q, p_d;

    always_comb begin
        p_d = p_q;
        if (load_i) begin
            p_d = CNT_W'(WIDTH);
        end else if (dec_i && (p_q != '0)) begin
            p_d = p_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign zero_o = (p_q == '0);
endmodule

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath driven by the controller's one-cycle strobes.
// Optional MULT_SELFCHECK_EN adds a behavioural shadow product and a sticky err flag.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_regs,
    input  logic               add_regs,
    input  logic               shift_regs,
    input  logic               decre_p,
    input  logic               ready_in,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               zero,
    output logic               pulso,
    output logic [2*WIDTH-1:0] product,
    output logic               product_valid,
    output logic               busy,
    output logic               err
);
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, q_q, q_d;
    logic               c_q, c_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               pv_q, pv_d, busy_q, busy_d;
    logic [WIDTH:0]     sum;

    assign sum = {1'b0, a_q} + {1'b0, b_q};

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        q_d    = q_q;
        prod_d = prod_q;
        pv_d   = pv_q;
        busy_d = busy_q;
        if (load_regs) begin
            a_d    = '0;
            c_d    = 1'b0;
            b_d    = multiplicand;
            q_d    = multiplier;
            busy_d = 1'b1;
            pv_d   = 1'b0;
        end else begin
            // A simultaneous add+shift shifts the fresh sum, so C never lands in the result.
            if (add_regs && shift_regs) begin
                {c_d, a_d, q_d} = {1'b0, sum, q_q[WIDTH-1:1]};
            end else if (add_regs) begin
                {c_d, a_d} = sum;
            end else if (shift_regs) begin
                {c_d, a_d, q_d} = {1'b0, c_q, a_q, q_q[WIDTH-1:1]};
            end
            if (ready_in) begin
                prod_d = {a_q, q_q};
                pv_d   = 1'b1;
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= 1'b0;
            q_q    <= '0;
            prod_q <= '0;
            pv_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
            q_q    <= q_d;
            prod_q <= prod_d;
            pv_q   <= pv_d;
            busy_q <= busy_d;
        end
    end

    mult_iter_counter #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (load_regs),
        .dec_i  (decre_p),
        .zero_o (zero)
    );

`ifdef MULT_SELFCHECK_EN
    logic [2*WIDTH-1:0] ref_q, ref_d;
    logic               err_q, err_d;

    always_comb begin
        ref_d = ref_q;
        err_d = err_q;
        if (load_regs) begin
            ref_d = {{WIDTH{1'b0}}, multiplicand} * {{WIDTH{1'b0}}, multiplier};
        end else if (ready_in && ({a_q, q_q} != ref_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ref_q <= '0;
            err_q <= 1'b0;
        end else begin
            ref_q <= ref_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign pulso         = q_q[0];
    assign product       = prod_q;
    assign product_valid = pv_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_mult_datapath.sv
// Randomized and directed bench for mult_datapath; reference products come from plain multiplication.
module tb_mult_datapath;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           load_regs, add_regs, shift_regs, decre_p, ready_in;
    logic [W-1:0]   multiplicand, multiplier;
    logic           zero, pulso, product_valid, busy, err;
    logic [2*W-1:0] product;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult_datapath #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .load_regs     (load_regs),
        .add_regs      (add_regs),
        .shift_regs    (shift_regs),
        .decre_p       (decre_p),
        .ready_in      (ready_in),
        .multiplicand  (multiplicand),
        .multiplier    (multiplier),
        .zero          (zero),
        .pulso         (pulso),
        .product       (product),
        .product_valid (product_valid),
        .busy          (busy),
        .err           (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_strobes();
        load_regs  = 1'b0;
        add_regs   = 1'b0;
        shift_regs = 1'b0;
        decre_p    = 1'b0;
        ready_in   = 1'b0;
    endtask

    // One clock: strobes set before the call are seen on this edge, then dropped.
    task automatic tick();
        @(posedge clk);
        #1;
        clr_strobes();
    endtask

    task automatic do_load(input logic [W-1:0] a, input logic [W-1:0] b);
        multiplicand = a;
        multiplier   = b;
        load_regs    = 1'b1;
        tick();
    endtask

    // Controller behaviour: add when pulso is set, then shift+decrement.
    task automatic run_iters(input int n, input bit merge, input bit idles);
        for (int i = 0; i < n; i++) begin
            if (idles && ($urandom_range(0, 3) == 0)) tick();
            if (pulso && merge) begin
                add_regs   = 1'b1;
                shift_regs = 1'b1;
                decre_p    = 1'b1;
                tick();
            end else begin
                if (pulso) begin
                    add_regs = 1'b1;
                    tick();
                end
                shift_regs = 1'b1;
                decre_p    = 1'b1;
                tick();
            end
        end
    endtask

    task automatic mul_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit merge, input bit idles);
        logic [2*W-1:0] exp_p;
        exp_p = (2*W)'(a) * (2*W)'(b);
        do_load(a, b);
        check({tag, ".busy_ld"}, busy, 1);
        check({tag, ".zero_ld"}, zero, 0);
        check({tag, ".pv_ld"}, product_valid, 0);
        run_iters(W, merge, idles);
        check({tag, ".zero_end"}, zero, 1);
        ready_in = 1'b1;
        tick();
        check({tag, ".product"}, product, exp_p);
        check({tag, ".pv"}, product_valid, 1);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".err"}, err, 0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        clr_strobes();
        multiplicand = '0;
        multiplier   = '0;
        rst = 1'b0;
        tick();
        tick();
        check("rst.zero", zero, 1);
        check("rst.pulso", pulso, 0);
        check("rst.product", product, 0);
        check("rst.pv", product_valid, 0);
        check("rst.busy", busy, 0);
        check("rst.err", err, 0);
        rst = 1'b1;

        decre_p = 1'b1;
        tick();
        check("decr_at_zero", zero, 1);

        mul_check("m13x11", 8'd13, 8'd11, 1'b0, 1'b0);
        mul_check("m255x255", 8'd255, 8'd255, 1'b0, 1'b0);
        mul_check("m0x200", 8'd0, 8'd200, 1'b0, 1'b0);
        mul_check("m200x0", 8'd200, 8'd0, 1'b0, 1'b0);

        ready_in = 1'b1;
        tick();
        check("relatch.product", product, 0);
        check("relatch.pv", product_valid, 1);

        for (int k = 0; k < 24; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            mul_check("rand", ra, rb, 1'($urandom), 1'($urandom));
        end

        // Reset in the middle of 9 x 7.
        do_load(8'd9, 8'd7);
        run_iters(3, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst.zero", zero, 1);
        check("midrst.busy", busy, 0);
        check("midrst.pv", product_valid, 0);
        check("midrst.pulso", pulso, 0);
        check("midrst.product", product, 0);
        add_regs = 1'b1;
        tick();
        ready_in = 1'b1;
        tick();
        check("midrst.aq_cleared", product, 0);
        mul_check("m9x7", 8'd9, 8'd7, 1'b0, 1'b0);

        // load together with ready: load wins.
        multiplicand = 8'd5;
        multiplier   = 8'd6;
        load_regs    = 1'b1;
        ready_in     = 1'b1;
        tick();
        check("ldrdy.zero", zero, 0);
        check("ldrdy.pv", product_valid, 0);
        check("ldrdy.busy", busy, 1);
        check("ldrdy.product_kept", product, 16'h003F);
        for (int i = 0; i < W - 1; i++) begin
            decre_p = 1'b1;
            tick();
        end
        check("cnt.seven_dec", zero, 0);
        decre_p = 1'b1;
        tick();
        check("cnt.eight_dec", zero, 1);
        decre_p = 1'b1;
        tick();
        check("cnt.saturate", zero, 1);

        // Build A=F0, B=20, C=0, Q=01, then one combined add+shift.
        do_load(8'h20, 8'h03);
        for (int i = 0; i < 7; i++) begin
            add_regs = 1'b1;
            tick();
        end
        shift_regs = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            add_regs = 1'b1;
            tick();
        end
        check("addsh.pulso_before", pulso, 1);
        add_regs   = 1'b1;
        shift_regs = 1'b1;
        tick();
        check("addsh.pulso_after", pulso, 0);
        ready_in = 1'b1;
        tick();
        check("addsh.aq", product, 16'h8800);
        shift_regs = 1'b1;
        tick();
        ready_in = 1'b1;
        tick();
        check("addsh.c_zero", product, 16'h4400);
        check("final.err", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
